mac_rr_scheduler: RTL and testbench

- Shares one pipelined, accumulating MAC datapath between NUM_REQ requesters.
- Each requester submits a burst of operand pairs, terminated by a last flag, and receives one accumulated result tagged with its requester ID.
- Sits between the requester-side streaming interfaces and a single MAC instance. It arbitrates round-robin, issues registered operands with an accumulator-clear marker, and tracks the in-flight burst through the MAC latency.

---
 rtl/mac_rr_scheduler_if.sv | 37 +++
 rtl/mac_rr_scheduler.sv | 146 ++++++++++++++
 tb/tb_mac_rr_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rr_scheduler_if.sv
// Requester, MAC-side and result signals of the shared MAC scheduler.
// The scheduler connects through the slave modport; the driving side uses master.
interface mac_rr_scheduler_if #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 40,
  parameter int ID_W         = $clog2(NUM_REQ)
);
  logic [NUM_REQ*INPUT_WIDTH-1:0] i_req_a;
  logic [NUM_REQ*INPUT_WIDTH-1:0] i_req_b;
  logic [NUM_REQ-1:0]             i_req_valid;
  logic [NUM_REQ-1:0]             i_req_last;
  logic [NUM_REQ-1:0]             o_req_ready;
  logic [INPUT_WIDTH-1:0]         o_mac_a;
  logic [INPUT_WIDTH-1:0]         o_mac_b;
  logic                           o_mac_valid;
  logic                           o_mac_clear;
  logic [OUTPUT_WIDTH-1:0]        i_mac_val;
  logic                           i_mac_valid;
  logic [OUTPUT_WIDTH-1:0]        o_res_val;
  logic                           o_res_valid;
  logic [ID_W-1:0]                o_res_id;
  logic                           o_busy;
  logic                           o_err;

  modport slave (
    input  i_req_a, i_req_b, i_req_valid, i_req_last, i_mac_val, i_mac_valid,
    output o_req_ready, o_mac_a, o_mac_b, o_mac_valid, o_mac_clear,
           o_res_val, o_res_valid, o_res_id, o_busy, o_err
  );

  modport master (
    output i_req_a, i_req_b, i_req_valid, i_req_last, i_mac_val, i_mac_valid,
    input  o_req_ready, o_mac_a, o_mac_b, o_mac_valid, o_mac_clear,
           o_res_val, o_res_valid, o_res_id, o_busy, o_err
  );
endinterface

// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined accumulating MAC between NUM_REQ
// requesters; one tagged result per burst.
//
// state | meaning
// IDLE  | no burst owned; arbitrate among valid requesters from the pointer
// BURST | granted requester streams operand beats to the MAC
// DRAIN | last beat issued; wait for its marker to reach the MAC output stage
module mac_rr_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 40,
  parameter int MAC_LATENCY  = 4,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic i_clk,
  input  logic i_rst,
  mac_rr_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                  state;
  logic [ID_W-1:0]         ptr;
  logic [ID_W-1:0]         grant;
  logic                    first_beat;
  logic [MAC_LATENCY:0]    tag_sr;
  logic [NUM_REQ-1:0]      ready_q;
  logic [INPUT_WIDTH-1:0]  mac_a_q;
  logic [INPUT_WIDTH-1:0]  mac_b_q;
  logic                    mac_valid_q;
  logic                    mac_clear_q;
  logic [OUTPUT_WIDTH-1:0] res_val_q;
  logic                    res_valid_q;
  logic [ID_W-1:0]         res_id_q;
  logic                    err_q;

  logic [INPUT_WIDTH-1:0]  req_a_arr [NUM_REQ];
  logic [INPUT_WIDTH-1:0]  req_b_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_a_arr[k] = bus.i_req_a[k*INPUT_WIDTH +: INPUT_WIDTH];
    assign req_b_arr[k] = bus.i_req_b[k*INPUT_WIDTH +: INPUT_WIDTH];
  end

  logic            beat_acc;
  logic            beat_last;
  logic [ID_W-1:0] grant_inc;

  assign beat_acc  = (state == BURST) && ready_q[grant] && bus.i_req_valid[grant];
  assign beat_last = bus.i_req_last[grant];
  assign grant_inc = (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + ID_W'(1);

  // Descending scan so the lowest offset from the pointer wins.
  logic            arb_hit;
  logic [ID_W-1:0] arb_pick;
  logic [ID_W-1:0] cand;

  always_comb begin
    arb_hit  = 1'b0;
    arb_pick = ptr;
    cand     = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (bus.i_req_valid[cand]) begin
        arb_hit  = 1'b1;
        arb_pick = cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      first_beat  <= 1'b0;
      tag_sr      <= '0;
      ready_q     <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_valid_q <= 1'b0;
      mac_clear_q <= 1'b0;
      res_val_q   <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      mac_valid_q <= 1'b0;
      mac_clear_q <= 1'b0;
      res_valid_q <= 1'b0;
      // Marker of the last beat travels alongside the MAC pipeline.
      tag_sr      <= {tag_sr[MAC_LATENCY-1:0], beat_acc && beat_last};

      if (beat_acc) begin
        mac_a_q     <= req_a_arr[grant];
        mac_b_q     <= req_b_arr[grant];
        mac_valid_q <= 1'b1;
        mac_clear_q <= first_beat;
        first_beat  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arb_hit) begin
            grant      <= arb_pick;
            ready_q    <= NUM_REQ'(1) << arb_pick;
            first_beat <= 1'b1;
            state      <= BURST;
          end
        end
        BURST: begin
          if (beat_acc && beat_last) begin
            ready_q <= '0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (tag_sr[MAC_LATENCY]) begin
            if (bus.i_mac_valid) begin
              res_val_q   <= bus.i_mac_val;
              res_id_q    <= grant;
              res_valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            ptr   <= grant_inc;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = ready_q;
  assign bus.o_mac_a     = mac_a_q;
  assign bus.o_mac_b     = mac_b_q;
  assign bus.o_mac_valid = mac_valid_q;
  assign bus.o_mac_clear = mac_clear_q;
  assign bus.o_res_val   = res_val_q;
  assign bus.o_res_valid = res_valid_q;
  assign bus.o_res_id    = res_id_q;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed bench for mac_rr_scheduler: queued requester sources, a delay-line MAC
// model with a programmable result, and event logs checked against hand values.
module tb_mac_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int IW      = 16;
  localparam int OW      = 40;
  localparam int L       = 4;
  localparam int ID_W    = 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  mac_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .ID_W(ID_W)) bus ();

  mac_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .MAC_LATENCY(L), .ID_W(ID_W)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct packed {logic [IW-1:0] a; logic [IW-1:0] b; logic last; logic bub;} beat_t;
  typedef struct packed {logic [31:0] cyc; logic [ID_W-1:0] id; logic last;} acc_ev_t;
  typedef struct packed {logic [31:0] cyc; logic [IW-1:0] a; logic [IW-1:0] b; logic clr;} mac_ev_t;
  typedef struct packed {logic [31:0] cyc; logic [OW-1:0] val; logic [ID_W-1:0] id;} res_ev_t;

  beat_t   req_q [NUM_REQ][$];
  acc_ev_t acc_log[$];
  mac_ev_t mac_log[$];
  res_ev_t res_log[$];

  int           n_tests   = 0;
  int           n_fail    = 0;
  int           ready_bad = 0;
  int           edge_n    = 0;
  logic [OW-1:0] mac_resp;
  logic          mac_late;
  logic [L+1:0]  mac_pipe;
  logic          in_drain;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sources, MAC model and event logging; outputs sampled 1 time unit after the edge.
  always @(posedge i_clk) begin : mon
    logic [NUM_REQ-1:0]    acc_mask, pre_last, was_bub, va, vl;
    logic [NUM_REQ*IW-1:0] pa, pb;
    acc_ev_t ae;
    mac_ev_t me;
    res_ev_t re;
    edge_n++;
    acc_mask = bus.o_req_ready & bus.i_req_valid;
    pre_last = bus.i_req_last;
    for (int k = 0; k < NUM_REQ; k++)
      was_bub[k] = (req_q[k].size() > 0) && req_q[k][0].bub;
    #1;
    for (int k = 0; k < NUM_REQ; k++)
      if ((acc_mask[k] || was_bub[k]) && req_q[k].size() > 0) void'(req_q[k].pop_front());
    va = '0; vl = '0; pa = '0; pb = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_q[k].size() > 0 && !req_q[k][0].bub) begin
        va[k]            = 1'b1;
        vl[k]            = req_q[k][0].last;
        pa[k*IW +: IW]   = req_q[k][0].a;
        pb[k*IW +: IW]   = req_q[k][0].b;
      end
    end
    bus.i_req_valid = va;
    bus.i_req_last  = vl;
    bus.i_req_a     = pa;
    bus.i_req_b     = pb;

    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc_mask[k]) begin
        ae.cyc = edge_n; ae.id = ID_W'(k); ae.last = pre_last[k];
        acc_log.push_back(ae);
        if (pre_last[k]) in_drain = 1'b1;
      end
    end
    if (bus.o_mac_valid === 1'b1) begin
      me.cyc = edge_n; me.a = bus.o_mac_a; me.b = bus.o_mac_b; me.clr = bus.o_mac_clear;
      mac_log.push_back(me);
    end
    if (bus.o_res_valid === 1'b1) begin
      re.cyc = edge_n; re.val = bus.o_res_val; re.id = bus.o_res_id;
      res_log.push_back(re);
    end
    if (bus.o_busy !== 1'b1) in_drain = 1'b0;
    if ($countones(bus.o_req_ready) > 1 ||
        (bus.o_req_ready != '0 && (bus.o_busy !== 1'b1 || in_drain)))
      ready_bad++;

    mac_pipe        = {mac_pipe[L:0], bus.o_mac_valid === 1'b1};
    bus.i_mac_valid = mac_late ? mac_pipe[L+1] : mac_pipe[L];
    bus.i_mac_val   = bus.i_mac_valid ? mac_resp : '0;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic push(input int k, input logic [IW-1:0] a, input logic [IW-1:0] b,
                      input logic last, input logic bub);
    beat_t bt;
    bt.a = a; bt.b = b; bt.last = last; bt.bub = bub;
    req_q[k].push_back(bt);
  endtask

  task automatic clear_logs();
    acc_log.delete();
    mac_log.delete();
    res_log.delete();
  endtask

  task automatic wait_res(input int n, input string tag);
    int b = 0;
    while (res_log.size() < n && b < 200) begin cycles(1); b++; end
    chk(tag, res_log.size(), n);
    cycles(2);
  endtask

  task automatic wait_acc(input int n, input string tag);
    int b = 0;
    while (acc_log.size() < n && b < 200) begin cycles(1); b++; end
    chk(tag, acc_log.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while (bus.o_busy !== 1'b0 && b < 200) begin cycles(1); b++; end
    chk(tag, bus.o_busy, 0);
  endtask

  initial begin
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    bus.i_req_a = '0; bus.i_req_b = '0; bus.i_req_valid = '0; bus.i_req_last = '0;
    bus.i_mac_val = '0; bus.i_mac_valid = 1'b0;
    mac_resp = '0; mac_late = 1'b0; mac_pipe = '0; in_drain = 1'b0;

    // Reset state
    cycles(3);
    chk("rst_ready",     bus.o_req_ready, 0);
    chk("rst_mac_valid", bus.o_mac_valid, 0);
    chk("rst_mac_clear", bus.o_mac_clear, 0);
    chk("rst_mac_a",     bus.o_mac_a, 0);
    chk("rst_res_valid", bus.o_res_valid, 0);
    chk("rst_res_val",   bus.o_res_val, 0);
    chk("rst_res_id",    bus.o_res_id, 0);
    chk("rst_busy",      bus.o_busy, 0);
    chk("rst_err",       bus.o_err, 0);
    i_rst = 1'b0;

    // Two-beat burst on req0, MAC model answers 39
    clear_logs(); mac_resp = 39;
    push(0, 3, 4, 0, 0); push(0, 5, 6, 1, 0);
    wait_res(1, "t1_res_count");
    chk("t1_mac_count", mac_log.size(), 2);
    chk("t1_clr0", mac_log[0].clr, 1);
    chk("t1_a0",   mac_log[0].a, 3);
    chk("t1_b0",   mac_log[0].b, 4);
    chk("t1_clr1", mac_log[1].clr, 0);
    chk("t1_a1",   mac_log[1].a, 5);
    chk("t1_b1",   mac_log[1].b, 6);
    chk("t1_val",  res_log[0].val, 39);
    chk("t1_id",   res_log[0].id, 0);
    // Both logs record the edge that updated the output: mac on the accept edge,
    // result L+1 edges later (sampled at accept+2+L).
    chk("t1_issue_lat", mac_log[1].cyc - acc_log[1].cyc, 0);
    chk("t1_res_lat",   res_log[0].cyc - acc_log[1].cyc, L + 1);

    // Fairness with all requesters busy, starting from a reset pointer
    i_rst = 1'b1; cycles(2); i_rst = 1'b0;
    clear_logs(); mac_resp = 77;
    push(0, 1, 1, 0, 0); push(0, 1, 2, 1, 0); push(0, 9, 9, 0, 0); push(0, 9, 9, 1, 0);
    for (int k = 1; k < NUM_REQ; k++) begin
      push(k, IW'(k), 2, 0, 0); push(k, IW'(k), 3, 1, 0);
    end
    wait_res(5, "fair_res_count");
    for (int i = 0; i < 5; i++)
      chk($sformatf("fair_id%0d", i), res_log[i].id, exp_ids[i]);
    chk("fair_acc_count", acc_log.size(), 10);
    chk("fair_val", res_log[4].val, 77);

    // Bubbles: req2 drops valid for 3 cycles mid-burst
    clear_logs(); mac_resp = 20;
    push(2, 2, 3, 0, 0); push(2, 0, 0, 0, 1); push(2, 0, 0, 0, 1); push(2, 0, 0, 0, 1);
    push(2, 4, 5, 1, 0);
    wait_res(1, "bub_res_count");
    chk("bub_mac_count", mac_log.size(), 2);
    chk("bub_gap",  mac_log[1].cyc - mac_log[0].cyc, 4);
    chk("bub_clr0", mac_log[0].clr, 1);
    chk("bub_clr1", mac_log[1].clr, 0);
    chk("bub_a1",   mac_log[1].a, 4);
    chk("bub_id",   res_log[0].id, 2);
    chk("bub_val",  res_log[0].val, 20);

    // Single-beat burst on req1
    clear_logs(); mac_resp = 56;
    push(1, 7, 8, 1, 0);
    wait_res(1, "sb_res_count");
    chk("sb_mac_count", mac_log.size(), 1);
    chk("sb_clr", mac_log[0].clr, 1);
    chk("sb_a",   mac_log[0].a, 7);
    chk("sb_b",   mac_log[0].b, 8);
    chk("sb_val", res_log[0].val, 56);
    chk("sb_id",  res_log[0].id, 1);
    chk("sb_res_lat", res_log[0].cyc - acc_log[0].cyc, L + 1);

    // MAC answers one cycle late: sticky error, no result, next requester served
    clear_logs(); mac_late = 1'b1; mac_resp = 5;
    push(3, 1, 1, 1, 0);
    wait_acc(1, "lm_acc_count");
    wait_idle("lm_idle");
    chk("lm_err", bus.o_err, 1);
    cycles(4);
    chk("lm_no_res", res_log.size(), 0);
    mac_late = 1'b0; mac_resp = 9;
    push(2, 2, 2, 1, 0); push(0, 3, 3, 1, 0);
    wait_res(2, "lm_res_count");
    chk("lm_next_id0", res_log[0].id, 0);
    chk("lm_next_id1", res_log[1].id, 2);
    chk("lm_err_sticky", bus.o_err, 1);

    // Reset during DRAIN
    clear_logs(); mac_resp = 11;
    push(1, 9, 9, 1, 0);
    wait_acc(1, "dr_acc_count");
    cycles(2);
    i_rst = 1'b1;
    cycles(1);
    chk("dr_ready",     bus.o_req_ready, 0);
    chk("dr_mac_valid", bus.o_mac_valid, 0);
    chk("dr_mac_a",     bus.o_mac_a, 0);
    chk("dr_res_valid", bus.o_res_valid, 0);
    chk("dr_res_val",   bus.o_res_val, 0);
    chk("dr_res_id",    bus.o_res_id, 0);
    chk("dr_busy",      bus.o_busy, 0);
    chk("dr_err",       bus.o_err, 0);
    i_rst = 1'b0;
    cycles(12);
    chk("dr_no_res", res_log.size(), 0);
    push(3, 1, 1, 1, 0); push(0, 1, 1, 1, 0);
    wait_res(2, "dr_res_count");
    chk("dr_ptr_id0", res_log[0].id, 0);
    chk("dr_ptr_id1", res_log[1].id, 3);

    chk("ready_exclusive", ready_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
